q_writeback_fwd: RTL and testbench

- Write-side companion to the Q-table read-delay pipeline.
- Accepts Q-value updates (state, action, new Q) and issues registered single-cycle writes to the Q-RAM.
- Keeps a short history of recent writes so the read path can forward fresh data. This resolves the read-after-write hazard created by the delayed state/action/reward alignment.
- Sits between the Q-update arithmetic and the Q-RAM write port; also taps the RAM read-data return.

---
 rtl/q_writeback_fwd_pkg.sv | 11 +
 rtl/q_writeback_fwd_if.sv | 36 +++
 rtl/q_writeback_fwd_history.sv | 59 +++++
 rtl/q_writeback_fwd.sv | 91 +++++++++
 tb/tb_q_writeback_fwd.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/q_writeback_fwd_pkg.sv
// q_pkg: shared widths, types and address helper for the Q-table write-back path
package q_pkg;
  localparam int STATE_W = 6;
  localparam int ACT_W = 2;
  localparam int DATA_W = 16;
  typedef logic [STATE_W+ACT_W-1:0] q_addr_t;
  typedef logic [DATA_W-1:0] q_data_t;
  function automatic q_addr_t q_addr(input logic [STATE_W-1:0] s, input logic [ACT_W-1:0] a);
    return {s, a};
  endfunction
endpackage

// File: rtl/q_writeback_fwd_if.sv
// q_writeback_fwd_if: update, Q-RAM and read-return signals (stat ports with Q_WB_FWD_STATS_EN)
interface q_writeback_fwd_if;
  import q_pkg::*;
  logic wr_valid;
  logic [STATE_W-1:0] wr_state;
  logic [ACT_W-1:0] wr_action;
  q_data_t wr_data;
  logic ram_we;
  q_addr_t ram_waddr;
  q_data_t ram_wdata;
  logic rd_valid;
  logic [STATE_W-1:0] rd_state;
  logic [ACT_W-1:0] rd_action;
  q_data_t ram_rdata;
  logic rd_out_valid;
  q_data_t rd_out_data;
  logic rd_out_fwd;
`ifdef Q_WB_FWD_STATS_EN
  logic [15:0] stat_reads;
  logic [15:0] stat_fwd_hits;
`endif
  modport slave (
    input wr_valid, wr_state, wr_action, wr_data, rd_valid, rd_state, rd_action, ram_rdata,
    output ram_we, ram_waddr, ram_wdata, rd_out_valid, rd_out_data, rd_out_fwd
`ifdef Q_WB_FWD_STATS_EN
    , output stat_reads, stat_fwd_hits
`endif
  );
  modport master (
    output wr_valid, wr_state, wr_action, wr_data, rd_valid, rd_state, rd_action, ram_rdata,
    input ram_we, ram_waddr, ram_wdata, rd_out_valid, rd_out_data, rd_out_fwd
`ifdef Q_WB_FWD_STATS_EN
    , input stat_reads, stat_fwd_hits
`endif
  );
endinterface

// File: rtl/q_writeback_fwd_history.sv
// q_fwd_history: circular buffer of recent Q-RAM writes with newest-first address match
module q_fwd_history
  import q_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_valid,
  input  q_addr_t push_addr,
  input  q_data_t push_data,
  input  q_addr_t lookup_addr,
  output logic    hit,
  output q_data_t hit_data
);
  localparam int PW = $clog2(DEPTH);
  logic [DEPTH-1:0] valid_q, valid_d;
  q_addr_t addr_q [DEPTH];
  q_addr_t addr_d [DEPTH];
  q_data_t data_q [DEPTH];
  q_data_t data_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, idx;
  always_comb begin
    valid_d = valid_q;
    addr_d = addr_q;
    data_d = data_q;
    wptr_d = wptr_q;
    if (push_valid) begin
      valid_d[wptr_q] = 1'b1;
      addr_d[wptr_q] = push_addr;
      data_d[wptr_q] = push_data;
      wptr_d = (int'(wptr_q) == DEPTH - 1) ? '0 : wptr_q + PW'(1);
    end
  end
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = PW'((int'(wptr_q) + k) % DEPTH);
      if (valid_q[idx] && addr_q[idx] == lookup_addr) begin
        hit = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= '0;
      addr_q <= '{default: '0};
      data_q <= '{default: '0};
      wptr_q <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wptr_q <= wptr_d;
    end
endmodule

// File: rtl/q_writeback_fwd.sv
// q_writeback_fwd: registered Q-RAM writes plus RAW forwarding on the delayed read return (stats with Q_WB_FWD_STATS_EN)
module q_writeback_fwd
  import q_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int HIST_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  q_writeback_fwd_if.slave bus
);
  localparam int L = RD_LAT - 1;
  logic ram_we_q, ram_we_d;
  q_addr_t ram_waddr_q, ram_waddr_d;
  q_data_t ram_wdata_q, ram_wdata_d;
  logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
  q_addr_t rd_addr_q [RD_LAT];
  q_addr_t rd_addr_d [RD_LAT];
  logic rd_out_valid_q, rd_out_valid_d, rd_out_fwd_q, rd_out_fwd_d;
  q_data_t rd_out_data_q, rd_out_data_d;
  logic hist_hit, byp_hit;
  q_data_t hist_data;
  q_fwd_history #(.DEPTH(HIST_DEPTH)) u_hist (
    .clk(clk),
    .rst_n(rst_n),
    .push_valid(ram_we_q),
    .push_addr(ram_waddr_q),
    .push_data(ram_wdata_q),
    .lookup_addr(rd_addr_q[L]),
    .hit(hist_hit),
    .hit_data(hist_data)
  );
  always_comb begin
    ram_we_d = bus.wr_valid;
    ram_waddr_d = bus.wr_valid ? q_addr(bus.wr_state, bus.wr_action) : ram_waddr_q;
    ram_wdata_d = bus.wr_valid ? bus.wr_data : ram_wdata_q;
    rd_vld_d[0] = bus.rd_valid;
    rd_addr_d[0] = q_addr(bus.rd_state, bus.rd_action);
    for (int i = 1; i < RD_LAT; i++) begin
      rd_vld_d[i] = rd_vld_q[i-1];
      rd_addr_d[i] = rd_addr_q[i-1];
    end
    byp_hit = ram_we_q && ram_waddr_q == rd_addr_q[L];
    rd_out_valid_d = rd_vld_q[L];
    rd_out_fwd_d = rd_vld_q[L] ? byp_hit || hist_hit : rd_out_fwd_q;
    rd_out_data_d = !rd_vld_q[L] ? rd_out_data_q : byp_hit ? ram_wdata_q : hist_hit ? hist_data : bus.ram_rdata;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ram_we_q <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      rd_vld_q <= '0;
      rd_addr_q <= '{default: '0};
      rd_out_valid_q <= 1'b0;
      rd_out_data_q <= '0;
      rd_out_fwd_q <= 1'b0;
    end else begin
      ram_we_q <= ram_we_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdata_q <= ram_wdata_d;
      rd_vld_q <= rd_vld_d;
      rd_addr_q <= rd_addr_d;
      rd_out_valid_q <= rd_out_valid_d;
      rd_out_data_q <= rd_out_data_d;
      rd_out_fwd_q <= rd_out_fwd_d;
    end
  assign bus.ram_we = ram_we_q;
  assign bus.ram_waddr = ram_waddr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.rd_out_valid = rd_out_valid_q;
  assign bus.rd_out_data = rd_out_data_q;
  assign bus.rd_out_fwd = rd_out_fwd_q;
`ifdef Q_WB_FWD_STATS_EN
  logic [15:0] stat_reads_q, stat_reads_d, stat_fwd_hits_q, stat_fwd_hits_d;
  always_comb begin
    stat_reads_d = rd_out_valid_q && stat_reads_q != 16'hFFFF ? stat_reads_q + 16'd1 : stat_reads_q;
    stat_fwd_hits_d = rd_out_valid_q && rd_out_fwd_q && stat_fwd_hits_q != 16'hFFFF ? stat_fwd_hits_q + 16'd1 : stat_fwd_hits_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_reads_q <= '0;
      stat_fwd_hits_q <= '0;
    end else begin
      stat_reads_q <= stat_reads_d;
      stat_fwd_hits_q <= stat_fwd_hits_d;
    end
  assign bus.stat_reads = stat_reads_q;
  assign bus.stat_fwd_hits = stat_fwd_hits_q;
`endif
endmodule

// File: tb/tb_q_writeback_fwd.sv
// tb_q_writeback_fwd: scoreboard bench with a latency-RD_LAT Q-RAM model
module tb_q_writeback_fwd;
  import q_pkg::*;
  localparam int RD_LAT = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [DATA_W:0] sb[$];
  logic [DATA_W:0] exp_v;
  q_data_t mem [256] = '{default: 16'h0011};
  q_data_t rpipe [RD_LAT] = '{default: '0};
  q_writeback_fwd_if bus();
  q_writeback_fwd #(.RD_LAT(RD_LAT), .HIST_DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
    rpipe[0] <= mem[{bus.rd_state, bus.rd_action}];
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.ram_rdata = rpipe[RD_LAT-1];
  always @(negedge clk)
    if (rst_n && bus.rd_out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got fwd=%b data=%h required no result", bus.rd_out_fwd, bus.rd_out_data);
      end else begin
        exp_v = sb.pop_front();
        if ({bus.rd_out_fwd, bus.rd_out_data} !== exp_v) begin
          errors++;
          $display("FAIL rd_result got fwd=%b data=%h required fwd=%b data=%h", bus.rd_out_fwd, bus.rd_out_data, exp_v[DATA_W], exp_v[DATA_W-1:0]);
        end
      end
    end
  task automatic idle();
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
  endtask
  task automatic set_wr(input q_addr_t a, input q_data_t d);
    bus.wr_valid = 1'b1;
    {bus.wr_state, bus.wr_action} = a;
    bus.wr_data = d;
  endtask
  task automatic set_rd(input q_addr_t a, input q_data_t d, input logic f);
    bus.rd_valid = 1'b1;
    {bus.rd_state, bus.rd_action} = a;
    sb.push_back({f, d});
  endtask
  task automatic drain();
    for (int n = 0; n < 40 && sb.size() != 0; n++) begin
      @(negedge clk);
      #1;
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic check_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending required 0", name, sb.size());
      sb.delete();
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.ram_we, bus.ram_waddr, bus.ram_wdata, bus.rd_out_valid, bus.rd_out_data, bus.rd_out_fwd} !== 43'd0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b wa=%h wd=%h ov=%b od=%h of=%b required all 0", bus.ram_we, bus.ram_waddr, bus.ram_wdata, bus.rd_out_valid, bus.rd_out_data, bus.rd_out_fwd);
    end
    rst_n = 1'b1;
  endtask
  task automatic test_reset_mid_read();
    logic bad;
    @(negedge clk);
    set_wr(8'h0D, 16'hBEEF);
    bus.rd_valid = 1'b1;
    {bus.rd_state, bus.rd_action} = 8'h05;
    @(negedge clk);
    idle();
    checks++;
    if (bus.ram_we !== 1'b1) begin
      errors++;
      $display("FAIL prereset_we got %b required 1", bus.ram_we);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ram_we, bus.ram_waddr, bus.ram_wdata, bus.rd_out_valid, bus.rd_out_data, bus.rd_out_fwd} !== 43'd0) begin
      errors++;
      $display("FAIL midreset_outputs got we=%b wa=%h wd=%h ov=%b required all 0", bus.ram_we, bus.ram_waddr, bus.ram_wdata, bus.rd_out_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rd_out_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL dropped_read got rd_out_valid=1 required 0");
    end
  endtask
  task automatic test_raw();
    int lat;
    @(negedge clk);
    set_wr(8'h0D, 16'h00AA);
    set_rd(8'h0D, 16'h00AA, 1'b1);
    @(negedge clk);
    idle();
    lat = 1;
    while (!bus.rd_out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL raw_latency got %0d required 3", lat);
    end
    drain();
    check_drained("raw");
  endtask
  task automatic test_single_write();
    @(negedge clk);
    set_wr({6'd3, 2'd1}, 16'h1234);
    @(negedge clk);
    idle();
    checks++;
    if ({bus.ram_we, bus.ram_waddr, bus.ram_wdata} !== {1'b1, 8'h0D, 16'h1234}) begin
      errors++;
      $display("FAIL write_issue got we=%b wa=%h wd=%h required 1 0d 1234", bus.ram_we, bus.ram_waddr, bus.ram_wdata);
    end
    @(negedge clk);
    checks++;
    if ({bus.ram_we, bus.ram_waddr, bus.ram_wdata} !== {1'b0, 8'h0D, 16'h1234}) begin
      errors++;
      $display("FAIL write_idle got we=%b wa=%h wd=%h required 0 0d 1234", bus.ram_we, bus.ram_waddr, bus.ram_wdata);
    end
  endtask
  task automatic test_newest_wins();
    @(negedge clk);
    set_wr(8'h0D, 16'h0001);
    @(negedge clk);
    set_wr(8'h0D, 16'h0002);
    @(negedge clk);
    idle();
    set_rd(8'h0D, 16'h0002, 1'b1);
    checks++;
    if (bus.ram_wdata !== 16'h0002) begin
      errors++;
      $display("FAIL newest_wdata got %h required 0002", bus.ram_wdata);
    end
    @(negedge clk);
    idle();
    drain();
    check_drained("newest");
  endtask
  task automatic test_bypass();
    @(negedge clk);
    set_wr(8'h10, 16'h0111);
    set_rd(8'h10, 16'h0222, 1'b1);
    @(negedge clk);
    bus.rd_valid = 1'b0;
    set_wr(8'h10, 16'h0222);
    @(negedge clk);
    idle();
    drain();
    check_drained("bypass");
  endtask
  task automatic test_eviction();
    q_addr_t a [5] = '{8'h0D, 8'h01, 8'h02, 8'h03, 8'h04};
    q_data_t d [5] = '{16'h0FF0, 16'h0101, 16'h0202, 16'h0303, 16'h0404};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_wr(a[i], d[i]);
    end
    @(negedge clk);
    idle();
    repeat (4) @(negedge clk);
    set_rd(8'h0D, 16'h0FF0, 1'b0);
    @(negedge clk);
    idle();
    drain();
    check_drained("eviction");
  endtask
  task automatic test_back_to_back_reads();
    q_addr_t a [5] = '{8'h20, 8'h21, 8'h01, 8'h04, 8'h0D};
    q_data_t d [5] = '{16'h0011, 16'h0011, 16'h0101, 16'h0404, 16'h0FF0};
    logic f [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_rd(a[i], d[i], f[i]);
    end
    @(negedge clk);
    idle();
    drain();
    check_drained("b2b_reads");
  endtask
  task automatic test_back_to_back_writes();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if ({bus.ram_we, bus.ram_waddr, bus.ram_wdata} !== {1'b1, 8'(8'h2F + i), 16'(16'hA000 + i - 1)}) begin
          errors++;
          $display("FAIL b2b_write%0d got we=%b wa=%h wd=%h required 1 %h %h", i, bus.ram_we, bus.ram_waddr, bus.ram_wdata, 8'(8'h2F + i), 16'(16'hA000 + i - 1));
        end
      end
      if (i < 3) set_wr(8'(8'h30 + i), 16'(16'hA000 + i));
      else idle();
    end
  endtask
`ifdef Q_WB_FWD_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({bus.stat_reads, bus.stat_fwd_hits} !== 32'd0) begin
      errors++;
      $display("FAIL stats_reset got %h %h required 0 0", bus.stat_reads, bus.stat_fwd_hits);
    end
    set_wr(8'h30, 16'h0AAA);
    @(negedge clk);
    set_wr(8'h31, 16'h0BBB);
    @(negedge clk);
    idle();
    set_rd(8'h30, 16'h0AAA, 1'b1);
    @(negedge clk);
    set_rd(8'h31, 16'h0BBB, 1'b1);
    @(negedge clk);
    set_rd(8'h3E, 16'h0011, 1'b0);
    @(negedge clk);
    idle();
    drain();
    check_drained("stats");
    checks++;
    if ({bus.stat_reads, bus.stat_fwd_hits} !== {16'd3, 16'd2}) begin
      errors++;
      $display("FAIL stats_count got reads=%0d hits=%0d required 3 2", bus.stat_reads, bus.stat_fwd_hits);
    end
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk);
      set_rd(8'h3F, 16'h0011, 1'b0);
    end
    @(negedge clk);
    idle();
    drain();
    check_drained("stats_sat");
    checks++;
    if ({bus.stat_reads, bus.stat_fwd_hits} !== {16'hFFFF, 16'd2}) begin
      errors++;
      $display("FAIL stats_saturate got reads=%h hits=%0d required ffff 2", bus.stat_reads, bus.stat_fwd_hits);
    end
  endtask
`endif
  initial begin
    idle();
    bus.wr_state = '0;
    bus.wr_action = '0;
    bus.wr_data = '0;
    bus.rd_state = '0;
    bus.rd_action = '0;
    test_reset();
    test_reset_mid_read();
    test_raw();
    test_single_write();
    test_newest_wins();
    test_bypass();
    test_eviction();
    test_back_to_back_reads();
    test_back_to_back_writes();
`ifdef Q_WB_FWD_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
